// File: rtl/dram_arb_pkg.sv
// Shared types and default widths for the DRAM port arbiter.
package dram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic OWN_IF  = 1'b0;
    localparam logic OWN_MEM = 1'b1;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int CNT_W_DEF  = 32;

endpackage

// File: rtl/dram_arb_select.sv
// Two-way grant picker: mem over fetch, or alternating on a tie when
// DRAM_ARB_ROUND_ROBIN_EN is defined (rr_ptr = owner granted last).
module dram_arb_select
    import dram_arb_pkg::*;
(
`ifdef DRAM_ARB_ROUND_ROBIN_EN
    input  logic rr_ptr,
`endif
    input  logic req_if,
    input  logic req_mem,
    output logic winner,
    output logic valid
);

    always_comb begin
        valid  = req_if | req_mem;
        winner = req_mem ? OWN_MEM : OWN_IF;
`ifdef DRAM_ARB_ROUND_ROBIN_EN
        if (req_if && req_mem)
            winner = (rr_ptr == OWN_MEM) ? OWN_IF : OWN_MEM;
`endif
    end

endmodule

// File: rtl/dram_port_arbiter.sv
// Shares one DRAM/cache port between instruction fetch and load/store.
// Optional tie-breaking by round robin: DRAM_ARB_ROUND_ROBIN_EN.
module dram_port_arbiter
    import dram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_gnt,
    output logic              mem_done,
    output logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    output logic              write_enable_DRAM,
    output logic              read_enable_DRAM,
    input  logic              miss,
    output logic [CNT_W-1:0]  stall_cnt
);

    state_t            state, next_state;
    logic              owner;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              winner, sel_valid, grant;

    assign grant = sel_valid && (state != ACCESS);

`ifdef DRAM_ARB_ROUND_ROBIN_EN
    logic rr_ptr;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)      rr_ptr <= OWN_IF;
        else if (grant) rr_ptr <= winner;
    end

    dram_arb_select u_sel (
        .rr_ptr  (rr_ptr),
        .req_if  (if_req),
        .req_mem (mem_req),
        .winner  (winner),
        .valid   (sel_valid)
    );
`else
    dram_arb_select u_sel (
        .req_if  (if_req),
        .req_mem (mem_req),
        .winner  (winner),
        .valid   (sel_valid)
    );
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state        = state;
        if_gnt            = grant && (winner == OWN_IF);
        mem_gnt           = grant && (winner == OWN_MEM);
        if_done           = 1'b0;
        mem_done          = 1'b0;
        addr              = '0;
        wdata             = '0;
        read_enable_DRAM  = 1'b0;
        write_enable_DRAM = 1'b0;
        case (state)
            IDLE: if (grant) next_state = ACCESS;
            ACCESS: begin
                addr              = lat_addr;
                wdata             = lat_wdata;
                read_enable_DRAM  = ~lat_we;
                write_enable_DRAM = lat_we;
                if (!miss) next_state = RESP;
            end
            RESP: begin
                if_done    = (owner == OWN_IF);
                mem_done   = (owner == OWN_MEM);
                next_state = grant ? ACCESS : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Request fields are captured only in the grant cycle; the port replays them.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            owner     <= OWN_IF;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (grant) begin
            owner     <= winner;
            lat_we    <= (winner == OWN_MEM) ? mem_we : 1'b0;
            lat_addr  <= (winner == OWN_MEM) ? mem_addr : if_addr;
            lat_wdata <= (winner == OWN_MEM) ? mem_wdata : '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            if_rdata  <= '0;
            mem_rdata <= '0;
        end else if (state == ACCESS && !miss && !lat_we) begin
            if (owner == OWN_IF) if_rdata  <= rdata;
            else                 mem_rdata <= rdata;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            stall_cnt <= '0;
        else if (state == ACCESS && miss && stall_cnt != {CNT_W{1'b1}})
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Directed bench for dram_port_arbiter; inputs change 1ns after posedge,
// outputs are sampled on the negedge. Tie checks follow DRAM_ARB_ROUND_ROBIN_EN.
module tb_dram_port_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic        if_req, mem_req, mem_we, miss;
    logic [31:0] if_addr, mem_addr, mem_wdata, rdata;
    logic        if_gnt, if_done, mem_gnt, mem_done;
    logic [31:0] if_rdata, mem_rdata, addr, wdata, stall_cnt;
    logic        we_dram, re_dram;

    logic        s_if_req, s_miss;
    logic        s_if_gnt, s_if_done, s_mem_gnt, s_mem_done, s_we, s_re;
    logic [31:0] s_if_rdata, s_mem_rdata, s_addr, s_wdata;
    logic [3:0]  s_stall;

    int checks = 0;
    int failures = 0;
    logic exp_mem;

    always #5 clk = ~clk;

    dram_port_arbiter u_dut (
        .clk(clk), .rstn(rstn),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_done(if_done), .if_rdata(if_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_done(mem_done),
        .mem_rdata(mem_rdata),
        .addr(addr), .wdata(wdata), .rdata(rdata),
        .write_enable_DRAM(we_dram), .read_enable_DRAM(re_dram),
        .miss(miss), .stall_cnt(stall_cnt)
    );

    dram_port_arbiter #(.CNT_W(4)) u_sat (
        .clk(clk), .rstn(rstn),
        .if_req(s_if_req), .if_addr(32'h0000_0500), .if_gnt(s_if_gnt),
        .if_done(s_if_done), .if_rdata(s_if_rdata),
        .mem_req(1'b0), .mem_we(1'b0), .mem_addr(32'h0),
        .mem_wdata(32'h0), .mem_gnt(s_mem_gnt), .mem_done(s_mem_done),
        .mem_rdata(s_mem_rdata),
        .addr(s_addr), .wdata(s_wdata), .rdata(32'h0),
        .write_enable_DRAM(s_we), .read_enable_DRAM(s_re),
        .miss(s_miss), .stall_cnt(s_stall)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        rstn = 1'b0; if_req = 0; mem_req = 0; mem_we = 0; miss = 0;
        if_addr = 0; mem_addr = 0; mem_wdata = 0; rdata = 0;
        s_if_req = 0; s_miss = 0;

        // reset state
        smp();
        chk("rst_gnt", {if_gnt, mem_gnt}, 0);
        chk("rst_en", {re_dram, we_dram}, 0);
        chk("rst_done", {if_done, mem_done}, 0);
        chk("rst_addr", addr, 0);
        chk("rst_stall", stall_cnt, 0);
        chk("rst_rdata", {if_rdata, mem_rdata}, 0);
        rstn = 1'b1;

        // single fetch, no miss
        nxt(); if_req = 1; if_addr = 32'h100;
        smp(); chk("f_if_gnt", if_gnt, 1); chk("f_mem_gnt", mem_gnt, 0);
        nxt(); if_req = 0; if_addr = 32'hFFFF; rdata = 32'hDEADBEEF; miss = 0;
        smp(); chk("f_re", re_dram, 1); chk("f_we", we_dram, 0);
        chk("f_addr", addr, 32'h100); chk("f_early_done", if_done, 0);
        nxt(); rdata = 0;
        smp(); chk("f_done", if_done, 1); chk("f_rdata", if_rdata, 32'hDEADBEEF);
        chk("f_re_resp", re_dram, 0);
        nxt();
        smp(); chk("f_done_pulse", if_done, 0); chk("f_rdata_hold", if_rdata, 32'hDEADBEEF);

        // store with 3 miss cycles
        nxt(); mem_req = 1; mem_we = 1; mem_addr = 32'h2000; mem_wdata = 32'h12345678;
        miss = 1; rdata = 32'hBADBAD00;
        smp(); chk("s_mem_gnt", mem_gnt, 1); chk("s_if_gnt", if_gnt, 0);
        nxt(); mem_req = 0; mem_we = 0; mem_addr = 0; mem_wdata = 0;
        for (int i = 0; i < 4; i++) begin
            miss = (i < 3);
            smp();
            chk("s_we_held", {we_dram, re_dram}, 2'b10);
            chk("s_addr", addr, 32'h2000);
            chk("s_wdata", wdata, 32'h12345678);
            chk("s_early_done", mem_done, 0);
            nxt();
        end
        smp(); chk("s_done", mem_done, 1); chk("s_we_off", we_dram, 0);
        chk("s_stall", stall_cnt, 3); chk("s_mem_rdata", mem_rdata, 0);
        chk("s_if_rdata", if_rdata, 32'hDEADBEEF);
        nxt();
        smp(); chk("s_done_pulse", mem_done, 0);

        // reset during a missing load
        nxt(); mem_req = 1; mem_we = 0; mem_addr = 32'h300; miss = 1; rdata = 32'h55;
        smp(); chk("r_gnt", mem_gnt, 1);
        nxt(); mem_req = 0;
        smp(); chk("r_re", re_dram, 1); chk("r_stall3", stall_cnt, 3);
        nxt();
        smp(); chk("r_stall4", stall_cnt, 4);
        #2 rstn = 1'b0;
        #1 chk("r_en_async", {re_dram, we_dram}, 0); chk("r_stall_clr", stall_cnt, 0);
        nxt();
        smp(); chk("r_no_done", mem_done, 0);
        rstn = 1'b1; miss = 0;
        nxt();
        smp(); chk("r_idle_done", {mem_done, if_done}, 0); chk("r_idle_en", re_dram, 0);
        chk("r_no_capture", mem_rdata, 0);
        chk("r_stall_after", stall_cnt, 0);

        // simultaneous fetch and load
        nxt(); if_req = 1; if_addr = 32'h80; mem_req = 1; mem_we = 0; mem_addr = 32'h40;
        smp(); chk("m_mem_gnt", mem_gnt, 1); chk("m_if_gnt", if_gnt, 0);
        nxt(); mem_req = 0; rdata = 32'hAAAA0040;
        smp(); chk("m_addr", addr, 32'h40); chk("m_re", re_dram, 1);
        chk("m_if_wait", if_gnt, 0);
        nxt(); rdata = 0;
        smp(); chk("m_mem_done", mem_done, 1); chk("m_mem_rdata", mem_rdata, 32'hAAAA0040);
        chk("m_if_gnt_resp", if_gnt, 1); chk("m_if_done_early", if_done, 0);
        nxt(); if_req = 0; rdata = 32'hBBBB0080;
        smp(); chk("m_if_addr", addr, 32'h80); chk("m_if_re", re_dram, 1);
        nxt(); rdata = 0;
        smp(); chk("m_if_done", if_done, 1); chk("m_if_rdata", if_rdata, 32'hBBBB0080);
        chk("m_mem_done_pulse", mem_done, 0);

        // repeated ties
        nxt();
        for (int k = 0; k < 4; k++) begin
            if_req = 1; if_addr = 32'h80; mem_req = 1; mem_we = 0; mem_addr = 32'h40;
`ifdef DRAM_ARB_ROUND_ROBIN_EN
            exp_mem = ((k % 2) == 0);
`else
            exp_mem = 1'b1;
`endif
            smp(); chk("t_mem_gnt", mem_gnt, exp_mem); chk("t_if_gnt", if_gnt, !exp_mem);
            nxt(); if_req = 0; mem_req = 0;
            nxt();
            nxt();
        end

        // stall counter saturation on the 4-bit instance
        s_if_req = 1; s_miss = 1;
        smp(); chk("c_gnt", s_if_gnt, 1);
        nxt(); s_if_req = 0;
        repeat (9) nxt();
        smp(); chk("c_mid", s_stall, 9); chk("c_re", s_re, 1);
        repeat (10) nxt();
        smp(); chk("c_sat", s_stall, 15); chk("c_no_done", s_if_done, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
